// File: rtl/user_mgr_obi_arb.sv
// -----------------------------------------------------------------------------
// user_mgr_obi_arb
//
// Round-robin arbiter that merges NumReq OBI requester ports onto a single OBI
// manager port. Up to MaxTrans transactions may be in flight at once.
//
// A-channel:
//   - The arbiter picks one active requester and drives the manager A-channel
//     combinationally from it.
//   - Once a request is presented without a grant, the selection is locked
//     until that grant arrives. This keeps the OBI request stable.
//
// R-channel:
//   - Responses come back in order. An ID FIFO records which requester was
//     granted at each handshake, and each response is routed to the head entry.
//   - A response that arrives with nothing outstanding sets a sticky
//     spurious_o flag, which only reset clears.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_i/addr_i/we_i/
//   be_i/wdata_i             per-requester A-channel
//   gnt_o/rvalid_o/err_o     per-requester grant, response valid, error
//   rdata_o                  shared response data (valid with rvalid_o)
//   mgr_req_o/mgr_addr_o/
//   mgr_we_o/mgr_be_o/
//   mgr_wdata_o              manager A-channel
//   mgr_gnt_i/mgr_rvalid_i/
//   mgr_rdata_i/mgr_err_i    manager grant and R-channel
//   busy_o                   any transaction outstanding
//   spurious_o               sticky: response seen with nothing outstanding
// -----------------------------------------------------------------------------
module user_mgr_obi_arb #(
  parameter int unsigned NumReq    = 2,
  parameter int unsigned MaxTrans  = 2,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,

  input  logic [NumReq-1:0]                       req_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]        addr_i,
  input  logic [NumReq-1:0]                       we_i,
  input  logic [NumReq-1:0][DataWidth/8-1:0]      be_i,
  input  logic [NumReq-1:0][DataWidth-1:0]        wdata_i,
  output logic [NumReq-1:0]                       gnt_o,
  output logic [NumReq-1:0]                       rvalid_o,
  output logic [NumReq-1:0]                       err_o,
  output logic [DataWidth-1:0]                    rdata_o,

  output logic                                    mgr_req_o,
  output logic [AddrWidth-1:0]                    mgr_addr_o,
  output logic                                    mgr_we_o,
  output logic [DataWidth/8-1:0]                  mgr_be_o,
  output logic [DataWidth-1:0]                    mgr_wdata_o,
  input  logic                                    mgr_gnt_i,
  input  logic                                    mgr_rvalid_i,
  input  logic [DataWidth-1:0]                    mgr_rdata_i,
  input  logic                                    mgr_err_i,

  output logic                                    busy_o,
  output logic                                    spurious_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] prio_q;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic [IdxW-1:0] id_q [MaxTrans];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            spurious_q;

  // ---------------------------------------------------------------------------
  // Round-robin pick
  // The search starts at prio_q and wraps around. The first active requester
  // found wins.
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] rr_idx;
  logic            rr_found;
  logic [IdxW-1:0] cand_idx;
  int              cand;

  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      cand     = (int'(prio_q) + i) % int'(NumReq);
      cand_idx = IdxW'(cand);
      if (!rr_found && req_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Selection and manager A-channel
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] sel_idx;
  logic            sel_valid;
  logic            fifo_full;
  logic            fifo_empty;
  logic            handshake;
  logic            pop;
  logic [IdxW-1:0] head_idx;

  // While locked, the request stays on the locked requester. Dropping req_i
  // during the lock is a protocol violation, so the request is simply held.
  assign sel_idx    = lock_q ? lock_idx_q : rr_idx;
  assign sel_valid  = lock_q | rr_found;

  assign fifo_full  = (count_q == CntW'(MaxTrans));
  assign fifo_empty = (count_q == '0);

  // Issue is blocked whenever the FIFO is full, even if a response pops in the
  // same cycle. There is deliberately no bypass path from pop to issue.
  assign mgr_req_o  = rst_ni & sel_valid & ~fifo_full;
  assign handshake  = mgr_req_o & mgr_gnt_i;

  always_comb begin
    mgr_addr_o  = '0;
    mgr_we_o    = 1'b0;
    mgr_be_o    = '0;
    mgr_wdata_o = '0;
    gnt_o       = '0;
    if (mgr_req_o) begin
      mgr_addr_o  = addr_i[sel_idx];
      mgr_we_o    = we_i[sel_idx];
      mgr_be_o    = be_i[sel_idx];
      mgr_wdata_o = wdata_i[sel_idx];
      gnt_o[sel_idx] = mgr_gnt_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  assign head_idx = id_q[rd_ptr_q];
  assign pop      = rst_ni & mgr_rvalid_i & ~fifo_empty;

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (pop) begin
      rvalid_o[head_idx] = 1'b1;
      err_o[head_idx]    = mgr_err_i;
    end
  end

  assign rdata_o    = mgr_rdata_i;
  assign busy_o     = (count_q != '0);
  assign spurious_o = spurious_q;

  // ---------------------------------------------------------------------------
  // Pointer helpers; MaxTrans and NumReq need not be powers of two
  // ---------------------------------------------------------------------------
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(MaxTrans - 1)) return '0;
    else                          return p + PtrW'(1);
  endfunction

  function automatic logic [IdxW-1:0] idx_inc(input logic [IdxW-1:0] k);
    if (k == IdxW'(NumReq - 1)) return '0;
    else                        return k + IdxW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration state: priority pointer and stable-request lock
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      if (handshake) begin
        prio_q <= idx_inc(sel_idx);
      end
      // Lock when the request is presented but not taken; any grant releases
      // the lock.
      lock_q     <= mgr_req_o & ~mgr_gnt_i;
      lock_idx_q <= sel_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // In-order ID FIFO and spurious flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MaxTrans); i++) begin
        id_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      spurious_q <= 1'b0;
    end else begin
      if (handshake) begin
        id_q[wr_ptr_q] <= sel_idx;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      unique case ({handshake, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (mgr_rvalid_i && fifo_empty) begin
        spurious_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_user_mgr_obi_arb.sv
module tb_user_mgr_obi_arb;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [1:0]        req_i;
  logic [1:0][31:0]  addr_i;
  logic [1:0]        we_i;
  logic [1:0][3:0]   be_i;
  logic [1:0][31:0]  wdata_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [1:0]        err_o;
  logic [31:0]       rdata_o;
  logic              mgr_req_o;
  logic [31:0]       mgr_addr_o;
  logic              mgr_we_o;
  logic [3:0]        mgr_be_o;
  logic [31:0]       mgr_wdata_o;
  logic              mgr_gnt_i;
  logic              mgr_rvalid_i;
  logic [31:0]       mgr_rdata_i;
  logic              mgr_err_i;
  logic              busy_o;
  logic              spurious_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;

  user_mgr_obi_arb #(
    .NumReq(2), .MaxTrans(2), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mgr_req_o(mgr_req_o), .mgr_addr_o(mgr_addr_o), .mgr_we_o(mgr_we_o),
    .mgr_be_o(mgr_be_o), .mgr_wdata_o(mgr_wdata_o),
    .mgr_gnt_i(mgr_gnt_i), .mgr_rvalid_i(mgr_rvalid_i),
    .mgr_rdata_i(mgr_rdata_i), .mgr_err_i(mgr_err_i),
    .busy_o(busy_o), .spurious_o(spurious_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_i        = 2'b11;
    addr_i[0]    = A0;
    addr_i[1]    = A1;
    we_i         = 2'b10;
    be_i[0]      = 4'hF;
    be_i[1]      = 4'hC;
    wdata_i[0]   = 32'h1111_1111;
    wdata_i[1]   = 32'h2222_2222;
    mgr_gnt_i    = 1'b1;
    mgr_rvalid_i = 1'b1;
    mgr_rdata_i  = 32'h0;
    mgr_err_i    = 1'b1;

    // Outputs held low during reset even with live inputs
    #2;
    check("rst_mgr_req", 64'(mgr_req_o), 64'(0));
    check("rst_gnt",     64'(gnt_o),     64'(0));
    check("rst_rvalid",  64'(rvalid_o),  64'(0));
    check("rst_err",     64'(err_o),     64'(0));
    check("rst_busy",    64'(busy_o),    64'(0));
    check("rst_spur",    64'(spurious_o), 64'(0));

    // A: release reset, both requesting, grant always high -> index 0 first
    @(negedge clk_i);
    rst_ni = 1'b1; mgr_rvalid_i = 1'b0; mgr_err_i = 1'b0;
    #1;
    check("a_gnt",  64'(gnt_o),      64'(2'b01));
    check("a_addr", 64'(mgr_addr_o), 64'(A0));
    check("a_we",   64'(mgr_we_o),   64'(0));

    // B: alternates to index 1
    @(negedge clk_i); #1;
    check("b_gnt",   64'(gnt_o),       64'(2'b10));
    check("b_addr",  64'(mgr_addr_o),  64'(A1));
    check("b_we",    64'(mgr_we_o),    64'(1));
    check("b_be",    64'(mgr_be_o),    64'(4'hC));
    check("b_wdata", 64'(mgr_wdata_o), 64'(32'h2222_2222));
    check("b_busy",  64'(busy_o),      64'(1));

    // C: FIFO full -> stall; a response pops index 0 with no bypass
    @(negedge clk_i);
    mgr_rvalid_i = 1'b1; mgr_rdata_i = 32'hA5A5_A5A5; mgr_err_i = 1'b0;
    #1;
    check("c_mgr_req", 64'(mgr_req_o),  64'(0));
    check("c_gnt",     64'(gnt_o),      64'(0));
    check("c_addr",    64'(mgr_addr_o), 64'(0));
    check("c_busy",    64'(busy_o),     64'(1));
    check("c_rvalid",  64'(rvalid_o),   64'(2'b01));
    check("c_err",     64'(err_o),      64'(2'b00));
    check("c_rdata",   64'(rdata_o),    64'(32'hA5A5_A5A5));

    // D: issue resumes, index 0 again
    @(negedge clk_i);
    mgr_rvalid_i = 1'b0;
    #1;
    check("d_mgr_req", 64'(mgr_req_o), 64'(1));
    check("d_gnt",     64'(gnt_o),     64'(2'b01));
    check("d_addr",    64'(mgr_addr_o), 64'(A0));

    // E: error response for head entry 1
    @(negedge clk_i);
    mgr_rvalid_i = 1'b1; mgr_err_i = 1'b1;
    #1;
    check("e_mgr_req", 64'(mgr_req_o), 64'(0));
    check("e_rvalid",  64'(rvalid_o),  64'(2'b10));
    check("e_err",     64'(err_o),     64'(2'b10));

    // F: no requests; response for index 0
    @(negedge clk_i);
    req_i = 2'b00; mgr_err_i = 1'b0;
    #1;
    check("f_mgr_req", 64'(mgr_req_o),  64'(0));
    check("f_addr",    64'(mgr_addr_o), 64'(0));
    check("f_rvalid",  64'(rvalid_o),   64'(2'b01));
    check("f_err",     64'(err_o),      64'(2'b00));
    check("f_busy",    64'(busy_o),     64'(1));

    // G: drained
    @(negedge clk_i);
    mgr_rvalid_i = 1'b0;
    #1;
    check("g_busy",   64'(busy_o),   64'(0));
    check("g_rvalid", 64'(rvalid_o), 64'(0));

    // H: pointer at 1, only req 0 -> wraps to 0
    @(negedge clk_i);
    req_i = 2'b01;
    #1;
    check("h_gnt", 64'(gnt_o), 64'(2'b01));

    // I: push and pop in the same cycle
    @(negedge clk_i);
    req_i = 2'b10; mgr_rvalid_i = 1'b1;
    #1;
    check("i_gnt",    64'(gnt_o),    64'(2'b10));
    check("i_rvalid", 64'(rvalid_o), 64'(2'b01));

    // J: occupancy unchanged at 1
    @(negedge clk_i);
    req_i = 2'b00; mgr_rvalid_i = 1'b0;
    #1;
    check("j_busy", 64'(busy_o), 64'(1));

    // K: response for index 1
    @(negedge clk_i);
    mgr_rvalid_i = 1'b1;
    #1;
    check("k_rvalid", 64'(rvalid_o), 64'(2'b10));

    // L: empty again
    @(negedge clk_i);
    mgr_rvalid_i = 1'b0;
    #1;
    check("l_busy", 64'(busy_o), 64'(0));

    // M..P: req 1 stalled 3 cycles, then req 0 rises; selection stays locked
    @(negedge clk_i);
    req_i = 2'b10; mgr_gnt_i = 1'b0;
    #1;
    check("m_mgr_req", 64'(mgr_req_o),  64'(1));
    check("m_addr",    64'(mgr_addr_o), 64'(A1));
    check("m_gnt",     64'(gnt_o),      64'(0));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i); #1;
      check("no_addr", 64'(mgr_addr_o), 64'(A1));
    end
    @(negedge clk_i);
    req_i = 2'b11;
    #1;
    check("p_addr_locked", 64'(mgr_addr_o), 64'(A1));

    // Q: grant arrives for the locked requester
    @(negedge clk_i);
    mgr_gnt_i = 1'b1;
    #1;
    check("q_gnt",  64'(gnt_o),      64'(2'b10));
    check("q_addr", 64'(mgr_addr_o), 64'(A1));

    // R: lock released, pointer at 0
    @(negedge clk_i);
    mgr_gnt_i = 1'b0;
    #1;
    check("r_addr", 64'(mgr_addr_o), 64'(A0));

    // S: grant index 0 -> two outstanding, pointer at 1
    @(negedge clk_i);
    mgr_gnt_i = 1'b1;
    #1;
    check("s_gnt", 64'(gnt_o), 64'(2'b01));

    // Asynchronous reset with two outstanding
    @(negedge clk_i);
    req_i = 2'b00; mgr_gnt_i = 1'b0;
    #1;
    check("pre_rst_busy", 64'(busy_o), 64'(1));
    #1 rst_ni = 1'b0;
    #1;
    check("async_rst_busy",    64'(busy_o),    64'(0));
    check("async_rst_mgr_req", 64'(mgr_req_o), 64'(0));

    // Pointer back at 0 after reset (would be 1 otherwise)
    @(negedge clk_i);
    rst_ni = 1'b1; req_i = 2'b11;
    #1;
    check("post_rst_addr", 64'(mgr_addr_o), 64'(A0));
    @(negedge clk_i);
    mgr_gnt_i = 1'b1;
    #1;
    check("post_rst_gnt", 64'(gnt_o), 64'(2'b01));

    // U: legitimate response
    @(negedge clk_i);
    req_i = 2'b00; mgr_gnt_i = 1'b0; mgr_rvalid_i = 1'b1;
    #1;
    check("u_rvalid", 64'(rvalid_o),   64'(2'b01));
    check("u_spur",   64'(spurious_o), 64'(0));

    // V: response with empty FIFO
    @(negedge clk_i); #1;
    check("v_rvalid", 64'(rvalid_o), 64'(2'b00));

    // W: spurious set and sticky
    @(negedge clk_i);
    mgr_rvalid_i = 1'b0;
    #1;
    check("w_spur", 64'(spurious_o), 64'(1));
    check("w_busy", 64'(busy_o),     64'(0));
    repeat (3) @(negedge clk_i);
    #1;
    check("spur_sticky", 64'(spurious_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    check("spur_rst", 64'(spurious_o), 64'(0));
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
